// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch / load-store RAM arbiter.
package mem_arb_pkg;

  // Arbiter FSM: idle, or in the acknowledge cycle of one requester.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  // Requester identifiers, also used as the value of the last-grant register.
  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Default geometry: 14-bit word address, fully populated 64 KiB RAM.
  localparam int DEF_AW    = 14;
  localparam int DEF_DEPTH = 16384;

  // Busy state that acknowledges the given requester.
  function automatic arb_state_t busy_state_for(input logic id);
    return (id == REQ_D) ? BUSY_D : BUSY_I;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker: a lone request wins outright,
// a contested cycle goes to whoever was not granted last.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last,
  output logic grant_i,
  output logic grant_d
);

  // Pick at most one winner; ties are broken against the last grantee.
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      if (last == REQ_I) begin
        grant_d = 1'b1;
      end else begin
        grant_i = 1'b1;
      end
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the core's fetch and load/store ports.
// One access per two cycles: grant + RAM strobe in IDLE, acknowledge with
// read data in the following BUSY cycle. Out-of-range addresses never reach
// the RAM and are answered with an error acknowledge instead.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          CLK,
  input  logic          RESET,
  // instruction fetch port (read only)
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [31:0]   i_rdata,
  output logic          i_ack,
  output logic          i_err,
  // load/store port
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  input  logic [3:0]    d_wmask,
  output logic [31:0]   d_rdata,
  output logic          d_ack,
  output logic          d_err,
  // RAM side
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_wmask,
  input  logic [31:0]   mem_rdata
);

  // One extra bit so DEPTH == 2**AW is representable in the comparison.
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  arb_state_t r_state;
  arb_state_t w_state_next;
  logic       r_last;   // requester granted most recently
  logic       r_err;    // granted address was out of range
  logic       r_wr;     // granted access was a store (no read data returned)

  logic       w_idle;
  logic       w_pick_i;
  logic       w_pick_d;
  logic       w_take_i;
  logic       w_take_d;
  logic       w_i_in_range;
  logic       w_d_in_range;

  logic [1:0] w_ack;
  logic [1:0] w_err;
  logic [31:0] w_rdata [2];

  assign w_idle       = (r_state == IDLE);
  assign w_i_in_range = ({1'b0, i_addr} < LP_DEPTH);
  assign w_d_in_range = ({1'b0, d_addr} < LP_DEPTH);

  rr_pick2 u_pick (
    .req_i   (i_req),
    .req_d   (d_req),
    .last    (r_last),
    .grant_i (w_pick_i),
    .grant_d (w_pick_d)
  );

  // A pick only becomes a grant in IDLE; RESET kills it immediately so
  // nothing reaches the RAM while reset is held, even with requests high.
  assign w_take_i = w_idle & w_pick_i & ~RESET;
  assign w_take_d = w_idle & w_pick_d & ~RESET;

  // Next-state: IDLE -> BUSY_x on grant, every BUSY state lasts one cycle.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_take_i) begin
          w_state_next = busy_state_for(REQ_I);
        end else if (w_take_d) begin
          w_state_next = busy_state_for(REQ_D);
        end
      end
      BUSY_I:  w_state_next = IDLE;
      BUSY_D:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State, last-grant and per-access flags; all latched at the grant edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_last  <= REQ_I;
      r_err   <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_take_i) begin
        r_last <= REQ_I;
        r_err  <= ~w_i_in_range;
        r_wr   <= 1'b0;
      end else if (w_take_d) begin
        r_last <= REQ_D;
        r_err  <= ~w_d_in_range;
        r_wr   <= |d_wmask;
      end
    end
  end

  // RAM strobe driven straight from the winner in its grant cycle; an
  // out-of-range winner leaves the whole RAM bus at zero.
  always_comb begin
    mem_en    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (w_take_i && w_i_in_range) begin
      mem_en   = 1'b1;
      mem_addr = i_addr;
    end else if (w_take_d && w_d_in_range) begin
      mem_en    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end
  end

  // Per-port acknowledge path: ack in the port's BUSY cycle, read data only
  // for successful reads, error flag only alongside the ack.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign w_ack[gi]   = ~RESET & (r_state == busy_state_for(1'(gi)));
    assign w_err[gi]   = w_ack[gi] & r_err;
    assign w_rdata[gi] = (w_ack[gi] && !r_err && !r_wr) ? mem_rdata : 32'h0;
  end

  assign i_ack   = w_ack[REQ_I];
  assign i_err   = w_err[REQ_I];
  assign i_rdata = w_rdata[REQ_I];
  assign d_ack   = w_ack[REQ_D];
  assign d_err   = w_err[REQ_D];
  assign d_rdata = w_rdata[REQ_D];

  // Only one requester can be acknowledged at a time.
  a_ack_onehot: assert property (@(posedge CLK) disable iff (RESET)
    !(i_ack && d_ack));

  // The RAM is only strobed from IDLE, and never with a write mask on fetch.
  a_en_idle: assert property (@(posedge CLK) disable iff (RESET)
    mem_en |-> (r_state == IDLE));
  a_fetch_no_write: assert property (@(posedge CLK) disable iff (RESET)
    (mem_en && w_take_i) |-> (mem_wmask == 4'h0));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural RAM. Stimulus pushes
// the expected acknowledge into a scoreboard; a monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int AW    = 14;
  localparam int DEPTH = 1024;

  logic          CLK;
  logic          RESET;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [31:0]   i_rdata;
  logic          i_ack;
  logic          i_err;
  logic          d_req;
  logic [AW-1:0] d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wmask;
  logic [31:0]   d_rdata;
  logic          d_ack;
  logic          d_err;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        port;   // 0 = fetch, 1 = load/store
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] ram [DEPTH];

  mem_port_arbiter #(.AW(AW), .DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ack     (i_ack),
    .i_err     (i_err),
    .d_req     (d_req),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wmask   (d_wmask),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_rdata (mem_rdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Behavioural single-port RAM: registered read-before-write, byte enables.
  always @(posedge CLK) begin
    if (mem_en) begin
      mem_rdata <= ram[mem_addr[9:0]];
      for (int b = 0; b < 4; b++) begin
        if (mem_wmask[b]) ram[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every acknowledge must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    logic port;
    forever begin
      @(negedge CLK);
      if (i_ack || d_ack) begin
        port = d_ack;
        $display("ack port=%s rdata=0x%08h err=%0b", port ? "D" : "I",
                 port ? d_rdata : i_rdata, port ? d_err : i_err);
        if (i_ack && d_ack) check("ack_both", 32'(1), 32'(0));
        if (sb_q.size() == 0) begin
          check("ack_unexpected", 32'(1), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("ack_port", 32'(port), 32'(e.port));
          check("ack_rdata", port ? d_rdata : i_rdata, e.rdata);
          check("ack_err", 32'(port ? d_err : i_err), 32'(e.err));
        end
      end
    end
  end

  // One access on one port from IDLE: checks the grant cycle on the RAM bus,
  // the ack one cycle later, then drops the request at the end of the ack.
  task automatic access(input logic port, input logic [AW-1:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input logic exp_en, input logic [31:0] exp_rdata,
                        input logic exp_err);
    exp_t e;
    @(posedge CLK); #1;
    if (port) begin
      d_req = 1'b1; d_addr = addr; d_wdata = wdata; d_wmask = wmask;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    e.port = port; e.rdata = exp_rdata; e.err = exp_err;
    sb_q.push_back(e);
    @(negedge CLK);
    check("grant_mem_en", 32'(mem_en), 32'(exp_en));
    check("grant_mem_addr", 32'(mem_addr), exp_en ? 32'(addr) : 32'h0);
    check("grant_mem_wmask", 32'(mem_wmask), (exp_en && port) ? 32'(wmask) : 32'h0);
    check("grant_mem_wdata", mem_wdata, (exp_en && port) ? wdata : 32'h0);
    @(negedge CLK);
    check("ack_latency", 32'(port ? d_ack : i_ack), 32'(1));
    @(posedge CLK); #1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"},    32'(mem_en),    32'h0);
    check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
    check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
    check({tag, "_mem_wmask"}, 32'(mem_wmask), 32'h0);
    check({tag, "_acks"},      32'({i_ack, d_ack, i_err, d_err}), 32'h0);
    check({tag, "_rdata"},     i_rdata | d_rdata, 32'h0);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    for (int a = 0; a < DEPTH; a++) ram[a] = 32'hC0DE_0000 | 32'(a);
    ram[32'h10] = 32'hDEAD_BEEF;
    ram[32'h20] = 32'hAAAA_AAAA;
    mem_rdata = 32'h0;

    // Reset with both requests high: RAM bus and acks must stay quiet.
    RESET = 1'b1;
    i_req = 1'b1; i_addr = 14'h10;
    d_req = 1'b1; d_addr = 14'h20; d_wdata = 32'hFFFF_FFFF; d_wmask = 4'hF;
    #3;
    check_all_zero("reset");
    @(posedge CLK); #1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(negedge CLK);
    check_all_zero("idle");

    // Single fetch, store, read-back of the merged word.
    access(1'b0, 14'h10, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    access(1'b1, 14'h20, 32'h1234_5678, 4'b0011, 1'b1, 32'h0, 1'b0);
    access(1'b1, 14'h20, 32'h0, 4'h0, 1'b1, 32'hAAAA_5678, 1'b0);

    // Range boundary on both ports; errors never strobe the RAM.
    access(1'b1, 14'd1024, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    access(1'b1, 14'd1023, 32'h0, 4'h0, 1'b1, 32'hC0DE_03FF, 1'b0);
    access(1'b1, 14'd2000, 32'h5555_5555, 4'hF, 1'b0, 32'h0, 1'b1);
    access(1'b0, 14'h3FFF, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1);
    access(1'b0, 14'h11, 32'h0, 4'h0, 1'b1, 32'hC0DE_0011, 1'b0);

    // Reset in the middle of a store's ack cycle: all outputs drop at once,
    // no ack is delivered (nothing pushed to the scoreboard).
    @(posedge CLK); #1;
    d_req = 1'b1; d_addr = 14'h50; d_wdata = 32'h0000_0055; d_wmask = 4'hF;
    @(negedge CLK);
    check("midrst_grant_en", 32'(mem_en), 32'h1);
    @(posedge CLK); #2;
    RESET = 1'b1;
    i_req = 1'b1; i_addr = 14'h30;
    #1;
    check_all_zero("midrst");
    @(negedge CLK);
    check("midrst_held_en", 32'(mem_en), 32'h0);
    @(posedge CLK); #1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Contention straight after reset: D, I, D, I with an ack every 2 cycles.
    @(posedge CLK); #1;
    i_req = 1'b1; i_addr = 14'h30;
    d_req = 1'b1; d_addr = 14'h40; d_wdata = '0; d_wmask = 4'h0;
    for (int k = 0; k < 4; k++) begin
      e.port  = (k % 2 == 0);
      e.rdata = (k % 2 == 0) ? 32'hC0DE_0040 : 32'hC0DE_0030;
      e.err   = 1'b0;
      sb_q.push_back(e);
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (c % 2 == 0) begin
        check("cont_mem_en", 32'(mem_en), 32'h1);
        check("cont_mem_addr", 32'(mem_addr), (c % 4 == 0) ? 32'h40 : 32'h30);
      end else begin
        check("cont_d_ack", 32'(d_ack), 32'((c % 4) == 1));
        check("cont_i_ack", 32'(i_ack), 32'((c % 4) == 3));
      end
    end
    @(posedge CLK); #1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_addr = '0;

    // Drain: every expected ack must have been seen.
    for (int w = 0; w < 20 && sb_q.size() != 0; w++) @(negedge CLK);
    check("sb_drained", 32'(sb_q.size()), 32'h0);
    @(negedge CLK);
    check_all_zero("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the SOC's single-port on-chip RAM between the RISC-V core's instruction-fetch port and its load/store port. Arbitrates round-robin, issues one access per two cycles, and returns a one-cycle acknowledge with read data to the winning requester. Out-of-range word addresses are rejected with an error acknowledge and never reach the RAM. Sits between the core and the RAM inside SOC.

## Interface
- AW, 14: word-address width (RAM depth in words = DEPTH).
- DEPTH, 16384: number of implemented 32-bit words; must be ≤ 2^AW.

- CLK  in  1  single system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request, held until i_ack.
- i_addr  in  AW  fetch word address, stable while i_req.
- i_rdata  out  32  fetch read data, valid while i_ack.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  with i_ack: address ≥ DEPTH.
- d_req  in  1  load/store request, held until d_ack.
- d_addr  in  AW  data word address.
- d_wdata  in  32  store data.
- d_wmask  in  4  byte enables; 0 = read, nonzero = write.
- d_rdata  out  32  load data, valid while d_ack.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  with d_ack: address ≥ DEPTH.
- mem_en  out  1  RAM access strobe.
- mem_addr  out  AW  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_wmask  out  4  RAM byte write enables (0 on fetch).
- mem_rdata  in  32  RAM read data, valid one cycle after mem_en.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D.
- IDLE: if no req, stay. If exactly one req, grant it. If both, grant the requester that was NOT granted last (`last` register; reset value = I, so the first contested grant goes to D).
- On grant in IDLE: drive mem_en=1 and mem_addr/wdata/wmask from the winner combinationally in the same cycle; update `last`; go to BUSY_I/BUSY_D.
- Out-of-range grant (addr ≥ DEPTH): mem_en stays 0, FSM still goes to BUSY_x, err flag registered to 1.
- BUSY_x: x_ack=1 for exactly this cycle, x_rdata = mem_rdata (0 on writes and on errors), x_err = registered flag; next state IDLE unconditionally.
- Requester deasserts req at the edge ending its ack cycle. A req still high in the following IDLE cycle is a new request.
- The non-granted requester's req is ignored until the FSM returns to IDLE. No queueing.
- The fetch port never writes. mem_wmask=0 whenever I is granted.

## Timing
- Latency: request seen in IDLE cycle N → mem_en in N → ack in N+1. Max throughput: one access per 2 cycles.
- Worst-case wait under contention: 2 cycles (one foreign access).
- Reset (asynchronous, any state, including mid-access): FSM→IDLE, last→I, err flags→0. Immediately forces mem_en=0, mem_wmask=0, mem_addr=0, mem_wdata=0, i_ack=d_ack=0, i_err=d_err=0, i_rdata=d_rdata=0. An in-flight access is dropped with no ack; a write already strobed may have completed in the RAM.
- Outputs in IDLE with no req: all zero.

## Structure
- Shared package `mem_arb_pkg`: state enum {IDLE, BUSY_I, BUSY_D}, requester IDs REQ_I=0 / REQ_D=1, default AW/DEPTH constants.
- One natural sub-module: `rr_pick2` is a combinational two-way round-robin picker (inputs: req_i, req_d, last; outputs: grant_i, grant_d). The FSM and the last-grant register stay in the top module.

## Test plan
- Single fetch: i_req, i_addr=0x10, RAM word 0x10=0xDEADBEEF → mem_en in cycle N, i_ack + i_rdata=0xDEADBEEF in N+1, i_err=0.
- Store then load: d_wmask=4'b0011, d_wdata=0x12345678 to 0x20 (old word 0xAAAAAAAA) → d_ack in N+1, d_rdata=0. Subsequent load of 0x20 returns 0xAAAA5678.
- Contention from reset: both req in the same cycle → D granted first, then I. With both held continuously, grants alternate D, I, D, I, with acks every 2 cycles.
- Out of range: DEPTH=1024, d_addr=1024 → mem_en never asserted, d_ack=1 and d_err=1 one cycle later. The next in-range request has err=0.
- Reset mid-access: assert RESET in BUSY_D → d_ack, mem_en and all outputs 0 immediately. After release, the FSM is in IDLE and a contested request goes to D.
